// File: rtl/iter_div_resp_if.sv
// Operand/result stream bundle between the execute stage (master) and an iterative divider (slave).
interface iter_div_resp_if #(
    parameter int DATA_W = 32
);
    logic                  s_axis_divisor_tvalid;
    logic                  s_axis_divisor_tready;
    logic [DATA_W-1:0]     s_axis_divisor_tdata;
    logic                  s_axis_dividend_tvalid;
    logic                  s_axis_dividend_tready;
    logic [DATA_W-1:0]     s_axis_dividend_tdata;
    logic                  m_axis_dout_tvalid;
    logic [2*DATA_W-1:0]   m_axis_dout_tdata;

    modport master (
        output s_axis_divisor_tvalid,
        input  s_axis_divisor_tready,
        output s_axis_divisor_tdata,
        output s_axis_dividend_tvalid,
        input  s_axis_dividend_tready,
        output s_axis_dividend_tdata,
        input  m_axis_dout_tvalid,
        input  m_axis_dout_tdata
    );

    modport slave (
        input  s_axis_divisor_tvalid,
        output s_axis_divisor_tready,
        input  s_axis_divisor_tdata,
        input  s_axis_dividend_tvalid,
        output s_axis_dividend_tready,
        input  s_axis_dividend_tdata,
        output m_axis_dout_tvalid,
        output m_axis_dout_tdata
    );
endinterface

// File: rtl/iter_div_resp.sv
// Iterative radix-2 restoring divider: one operand pair in, DATA_W iterations on magnitudes,
// sign fix-up, then a one-cycle {quotient, remainder} pulse.
module iter_div_resp #(
    parameter int SIGNED = 1,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           resetn,
    iter_div_resp_if.slave bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic                negQ_q, negQ_d;
    logic                negR_q, negR_d;
    logic [2*DATA_W-1:0] dout_q, dout_d;

    logic                accept;
    logic                divisorZero;
    logic                dvdNeg;
    logic                dvsNeg;
    logic [DATA_W:0]     shifted;
    logic [DATA_W-1:0]   diff;
    logic                fits;

    assign accept      = (state_q == IDLE) && bus.s_axis_divisor_tvalid && bus.s_axis_dividend_tvalid;
    assign divisorZero = (bus.s_axis_divisor_tdata == '0);
    // A zero divisor skips magnitude conversion so the raw dividend falls out as the remainder.
    assign dvdNeg      = (SIGNED != 0) && !divisorZero && bus.s_axis_dividend_tdata[DATA_W-1];
    assign dvsNeg      = (SIGNED != 0) && !divisorZero && bus.s_axis_divisor_tdata[DATA_W-1];

    // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom.
    assign shifted = {rem_q, dvd_q[DATA_W-1]};
    assign fits    = (shifted >= {1'b0, dvs_q});
    assign diff    = shifted[DATA_W-1:0] - dvs_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            negQ_q  <= 1'b0;
            negR_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            negQ_q  <= negQ_d;
            negR_q  <= negR_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        negQ_d  = negQ_q;
        negR_d  = negR_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                    dvd_d   = dvdNeg ? -bus.s_axis_dividend_tdata : bus.s_axis_dividend_tdata;
                    dvs_d   = dvsNeg ? -bus.s_axis_divisor_tdata : bus.s_axis_divisor_tdata;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    negQ_d  = dvdNeg ^ dvsNeg;
                    negR_d  = dvdNeg;
                end
            end
            CALC: begin
                rem_d = fits ? diff : shifted[DATA_W-1:0];
                dvd_d = {dvd_q[DATA_W-2:0], fits};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                dout_d  = {(negQ_q ? -dvd_q : dvd_q), (negR_q ? -rem_q : rem_q)};
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_axis_divisor_tready  = (state_q == IDLE);
    assign bus.s_axis_dividend_tready = (state_q == IDLE);
    assign bus.m_axis_dout_tvalid     = (state_q == DONE);
    assign bus.m_axis_dout_tdata      = dout_q;
endmodule
